// File: rtl/mem_bus_initiator.sv
// rtl/mem_bus_initiator.sv - bus master for the relay-computer memory: timed setup/strobe/hold cycles
module mem_bus_initiator #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] addr_bus_out,
    output logic        addr_bus_oe,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_oe,
    input  logic [7:0]  data_bus_in,
    output logic        mem_read,
    output logic        mem_write,
    output logic        busy
);

    localparam int MAXC_SS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAXC    = (MAXC_SS > HOLD_CYCLES) ? MAXC_SS : HOLD_CYCLES;
    localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;

    generate
        if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
            $error("mem_bus_initiator: SETUP/STROBE/HOLD_CYCLES must all be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          accept;
    logic          last;
    logic          wr_q;

    assign last = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The counter is reloaded with (duration - 1) on entry and the state advances when it reaches zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                    cnt_n   = CW'(SETUP_CYCLES - 1);
                end
            end
            SETUP: begin
                if (last) begin
                    state_n = STROBE;
                    cnt_n   = CW'(STROBE_CYCLES - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            STROBE: begin
                if (last) begin
                    state_n = HOLD;
                    cnt_n   = CW'(HOLD_CYCLES - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (last) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are flops decoded from the next state, so they line up with the state register without glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready    <= 1'b0;
            busy         <= 1'b0;
            wr_q         <= 1'b0;
            addr_bus_out <= '0;
            addr_bus_oe  <= 1'b0;
            data_bus_out <= '0;
            data_bus_oe  <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            req_ready   <= (state_n == IDLE);
            busy        <= (state_n != IDLE);
            addr_bus_oe <= (state_n != IDLE);
            if (accept) begin
                wr_q         <= req_write;
                addr_bus_out <= req_addr;
                data_bus_out <= req_write ? req_wdata : 8'h00;
                data_bus_oe  <= req_write;
            end else if (state_n == IDLE) begin
                addr_bus_out <= '0;
                data_bus_out <= '0;
                data_bus_oe  <= 1'b0;
            end
            mem_read  <= (state_n == STROBE) && !wr_q;
            mem_write <= (state_n == STROBE) && wr_q;
            rsp_valid <= (state == HOLD) && last;
            if (state == STROBE && last && !wr_q) begin
                rsp_rdata <= data_bus_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb/tb_mem_bus_initiator.sv - self-checking bench for mem_bus_initiator (default and 2/3/2 timing)
module tb_mem_bus_initiator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        rv [2];
    logic        rw [2];
    logic [15:0] ra [2];
    logic [7:0]  rd [2];
    logic [7:0]  din [2];
    logic [7:0]  rdv [2];

    logic        o_rdy [2];
    logic        o_rsp [2];
    logic [7:0]  o_rdata [2];
    logic [15:0] o_ao [2];
    logic        o_aoe [2];
    logic [7:0]  o_do [2];
    logic        o_doe [2];
    logic        o_mr [2];
    logic        o_mw [2];
    logic        o_busy [2];

    mem_bus_initiator dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[0]), .req_ready(o_rdy[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rd[0]),
        .rsp_valid(o_rsp[0]), .rsp_rdata(o_rdata[0]),
        .addr_bus_out(o_ao[0]), .addr_bus_oe(o_aoe[0]),
        .data_bus_out(o_do[0]), .data_bus_oe(o_doe[0]), .data_bus_in(din[0]),
        .mem_read(o_mr[0]), .mem_write(o_mw[0]), .busy(o_busy[0])
    );

    mem_bus_initiator #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[1]), .req_ready(o_rdy[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rd[1]),
        .rsp_valid(o_rsp[1]), .rsp_rdata(o_rdata[1]),
        .addr_bus_out(o_ao[1]), .addr_bus_oe(o_aoe[1]),
        .data_bus_out(o_do[1]), .data_bus_oe(o_doe[1]), .data_bus_in(din[1]),
        .mem_read(o_mr[1]), .mem_write(o_mw[1]), .busy(o_busy[1])
    );

    int ps [2] = '{1, 2};
    int pt [2] = '{2, 3};
    int ph [2] = '{1, 2};

    int checks = 0;
    int errors = 0;

    // Transaction-level model: age counts cycles since acceptance (1 = first cycle after the accepting edge).
    typedef struct {
        bit          active;
        int          age;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        bit          rsp;
        bit          ready;
        bit          acc;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t step(mdl_t cur, int s, int t, int h, logic v, logic w,
                                  logic [15:0] a, logic [7:0] wd, logic [7:0] di);
        mdl_t n = cur;
        n.acc = 1'b0;
        n.rsp = 1'b0;
        if (cur.active) begin
            if (!cur.wr && cur.age == s + t) n.rdata = di;
            if (cur.age == s + t + h) begin
                n.active = 1'b0;
                n.rsp    = 1'b1;
            end else begin
                n.age = cur.age + 1;
            end
        end else if (cur.ready && v === 1'b1) begin
            n.active = 1'b1;
            n.age    = 1;
            n.wr     = (w === 1'b1);
            n.addr   = a;
            n.wdata  = wd;
            n.acc    = 1'b1;
        end
        n.ready = !n.active;
        return n;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.active = 0; n.age = 0; n.wr = 0; n.addr = '0; n.wdata = '0;
        n.rdata = '0; n.rsp = 0; n.ready = 0; n.acc = 0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) m[d] = mdl_reset();
            else m[d] = step(m[d], ps[d], pt[d], ph[d], rv[d], rw[d], ra[d], rd[d], din[d]);
        end
    end

    // Read data is only the requested value in the final strobe cycle, so an early or late capture shows up.
    always @(negedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            din[d] = (m[d].active && !m[d].wr && m[d].age == ps[d] + pt[d]) ? rdv[d] : ~rdv[d];
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit act, strb;
            act  = m[d].active;
            strb = act && m[d].age > ps[d] && m[d].age <= ps[d] + pt[d];
            chk($sformatf("dut%0d req_ready", d), 32'(o_rdy[d]), 32'(m[d].ready));
            chk($sformatf("dut%0d busy", d), 32'(o_busy[d]), 32'(act));
            chk($sformatf("dut%0d addr_bus_oe", d), 32'(o_aoe[d]), 32'(act));
            chk($sformatf("dut%0d addr_bus_out", d), 32'(o_ao[d]), act ? 32'(m[d].addr) : 32'h0);
            chk($sformatf("dut%0d data_bus_oe", d), 32'(o_doe[d]), 32'(act && m[d].wr));
            chk($sformatf("dut%0d data_bus_out", d), 32'(o_do[d]), (act && m[d].wr) ? 32'(m[d].wdata) : 32'h0);
            chk($sformatf("dut%0d mem_read", d), 32'(o_mr[d]), 32'(strb && !m[d].wr));
            chk($sformatf("dut%0d mem_write", d), 32'(o_mw[d]), 32'(strb && m[d].wr));
            chk($sformatf("dut%0d rsp_valid", d), 32'(o_rsp[d]), 32'(m[d].rsp));
            chk($sformatf("dut%0d rsp_rdata", d), 32'(o_rdata[d]), 32'(m[d].rdata));
            chk($sformatf("dut%0d strobe_excl", d), 32'(o_mr[d] === 1'b1 && o_mw[d] === 1'b1), 32'h0);
        end
    end

    bit          cap_mr [0:15];
    bit          cap_mw [0:15];
    bit          cap_rsp [0:15];
    bit          cap_aoe [0:15];
    bit          cap_doe [0:15];
    logic [15:0] cap_ao [0:15];
    logic [7:0]  cap_rd [0:15];

    // Records outputs of cycles 1..n after the request already presented is accepted at edge 0.
    task automatic capture(int d, int n, int drop_at, bit chg, bit w, logic [15:0] a,
                           logic [7:0] wd, logic [7:0] rdval);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == drop_at) rv[d] = 1'b0;
            if (k == 1 && chg) begin
                rw[d] = w; ra[d] = a; rd[d] = wd; rdv[d] = rdval;
            end
            cap_mr[k]  = o_mr[d];
            cap_mw[k]  = o_mw[d];
            cap_rsp[k] = o_rsp[d];
            cap_aoe[k] = o_aoe[d];
            cap_doe[k] = o_doe[d];
            cap_ao[k]  = o_ao[d];
            cap_rd[k]  = o_rdata[d];
        end
    endtask

    task automatic present(int d, bit w, logic [15:0] a, logic [7:0] wd, logic [7:0] rdval);
        rv[d] = 1'b1; rw[d] = w; ra[d] = a; rd[d] = wd; rdv[d] = rdval;
    endtask

    task automatic issue(int d, bit w, logic [15:0] a, logic [7:0] wd, logic [7:0] rdval);
        int n = 0;
        present(d, w, a, wd, rdval);
        do begin
            @(negedge clk);
            n++;
        end while (!m[d].acc && n < 100);
        if (!m[d].acc) begin
            errors++;
            $display("FAIL issue_timeout: dut%0d request not accepted within 100 cycles", d);
        end
        rv[d] = 1'b0;
        rw[d] = 1'($urandom); ra[d] = 16'($urandom); rd[d] = 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; rw[d] = 0; ra[d] = '0; rd[d] = '0; rdv[d] = '0; din[d] = '0;
        end
        repeat (4) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                rv[d] = 1'($urandom); rw[d] = 1'($urandom);
                ra[d] = 16'($urandom); rd[d] = 8'($urandom);
            end
        end
        chk("reset req_ready", 32'(o_rdy[0]), 32'h0);
        for (int d = 0; d < 2; d++) rv[d] = 1'b0;
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("release req_ready", 32'(o_rdy[0]), 32'h1);

        present(0, 1'b1, 16'h1234, 8'hA5, 8'h00);
        capture(0, 6, 1, 0, 0, '0, '0, '0);
        chk("wr aoe c1", 32'(cap_aoe[1]), 32'h1);
        chk("wr aoe c4", 32'(cap_aoe[4]), 32'h1);
        chk("wr aoe c5", 32'(cap_aoe[5]), 32'h0);
        chk("wr doe c4", 32'(cap_doe[4]), 32'h1);
        chk("wr addr c1", 32'(cap_ao[1]), 32'h1234);
        chk("wr mw c1", 32'(cap_mw[1]), 32'h0);
        chk("wr mw c2", 32'(cap_mw[2]), 32'h1);
        chk("wr mw c3", 32'(cap_mw[3]), 32'h1);
        chk("wr mw c4", 32'(cap_mw[4]), 32'h0);
        chk("wr mr c2", 32'(cap_mr[2]), 32'h0);
        chk("wr rsp c4", 32'(cap_rsp[4]), 32'h0);
        chk("wr rsp c5", 32'(cap_rsp[5]), 32'h1);
        chk("wr rsp c6", 32'(cap_rsp[6]), 32'h0);

        present(0, 1'b0, 16'h7FFF, 8'h00, 8'h3C);
        capture(0, 6, 1, 0, 0, '0, '0, '0);
        chk("rd mr c2", 32'(cap_mr[2]), 32'h1);
        chk("rd mr c3", 32'(cap_mr[3]), 32'h1);
        chk("rd mr c4", 32'(cap_mr[4]), 32'h0);
        chk("rd doe c2", 32'(cap_doe[2]), 32'h0);
        chk("rd rdata c3", 32'(cap_rd[3]), 32'h00);
        chk("rd rdata c4", 32'(cap_rd[4]), 32'h3C);
        chk("rd rsp c5", 32'(cap_rsp[5]), 32'h1);

        present(0, 1'b1, 16'h0010, 8'h11, 8'h00);
        capture(0, 11, 6, 1, 1'b0, 16'h0010, 8'h00, 8'h5A);
        chk("b2b mw c2", 32'(cap_mw[2]), 32'h1);
        chk("b2b rsp c5", 32'(cap_rsp[5]), 32'h1);
        chk("b2b rdata c5", 32'(cap_rd[5]), 32'h3C);
        chk("b2b mr c6", 32'(cap_mr[6]), 32'h0);
        chk("b2b mr c7", 32'(cap_mr[7]), 32'h1);
        chk("b2b mr c8", 32'(cap_mr[8]), 32'h1);
        chk("b2b mr c9", 32'(cap_mr[9]), 32'h0);
        chk("b2b rdata c9", 32'(cap_rd[9]), 32'h5A);
        chk("b2b rsp c10", 32'(cap_rsp[10]), 32'h1);

        present(0, 1'b1, 16'h4321, 8'h77, 8'h00);
        @(negedge clk);
        rv[0] = 1'b0;
        @(negedge clk);
        chk("abort mw before", 32'(o_mw[0]), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("abort mw", 32'(o_mw[0]), 32'h0);
        chk("abort aoe", 32'(o_aoe[0]), 32'h0);
        chk("abort doe", 32'(o_doe[0]), 32'h0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        present(0, 1'b0, 16'h0ABC, 8'h00, 8'hC3);
        capture(0, 6, 1, 0, 0, '0, '0, '0);
        chk("post-abort mr c2", 32'(cap_mr[2]), 32'h1);
        chk("post-abort rdata c4", 32'(cap_rd[4]), 32'hC3);
        chk("post-abort rsp c5", 32'(cap_rsp[5]), 32'h1);

        present(1, 1'b1, 16'h2222, 8'h99, 8'h00);
        capture(1, 9, 1, 0, 0, '0, '0, '0);
        chk("p232 mw c2", 32'(cap_mw[2]), 32'h0);
        chk("p232 mw c3", 32'(cap_mw[3]), 32'h1);
        chk("p232 mw c5", 32'(cap_mw[5]), 32'h1);
        chk("p232 mw c6", 32'(cap_mw[6]), 32'h0);
        chk("p232 aoe c7", 32'(cap_aoe[7]), 32'h1);
        chk("p232 rsp c7", 32'(cap_rsp[7]), 32'h0);
        chk("p232 rsp c8", 32'(cap_rsp[8]), 32'h1);

        for (int i = 0; i < 200; i++) begin
            int d = i % 2;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(d, 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
        end
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
